// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of requester handshakes, shared memory port and
//               status signals around the memory port arbiter.
//               slave  = arbiter side, master = requesters + memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  // requester 0 (processor controller)
  logic              rq0_req;
  logic              rq0_we;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq0_gnt;
  logic              rq0_done;
  logic [DATA_W-1:0] rq0_rdata;
  // requester 1 (program loader / debug)
  logic              rq1_req;
  logic              rq1_we;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq1_gnt;
  logic              rq1_done;
  logic [DATA_W-1:0] rq1_rdata;
  // shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              busy;
  logic [1:0]        state;

  modport slave (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
    input  mem_rdata,
    output rq0_gnt, rq0_done, rq0_rdata,
    output rq1_gnt, rq1_done, rq1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, state
  );

  modport master (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata,
    output mem_rdata,
    input  rq0_gnt, rq0_done, rq0_rdata,
    input  rq1_gnt, rq1_done, rq1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, state
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter/sequencer for the single shared memory
//               port. Latches one request at a time, holds the memory for
//               MEM_LAT cycles, returns read data and pulses done.
//               MEM_LAT legal range is 1..15.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  // counter value loaded on grant; ACCESS ends when it reaches zero
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_gnt_q, last_gnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              grant;
  logic              grant_id;
  logic              first_acc;

  // The counter is loaded with LAT_M1 on grant, so the first ACCESS cycle
  // is recognised without an extra flag register.
  assign first_acc = (state_q == ACCESS) && (cnt_q == LAT_M1);

  // Arbitration: fresh round-robin in IDLE; in DONE only the non-owner may
  // be granted, since the owner is still dropping its request.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rq0_req && bus.rq1_req) begin
          grant    = 1'b1;
          grant_id = ~last_gnt_q;
        end else if (bus.rq0_req) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (bus.rq1_req) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
      end
      DONE: begin
        if (owner_q ? bus.rq0_req : bus.rq1_req) begin
          grant    = 1'b1;
          grant_id = ~owner_q;
        end
      end
      default: begin
        grant    = 1'b0;
        grant_id = 1'b0;
      end
    endcase
  end

  // Next-state logic: sequencing, latching on grant and read-data capture
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q) rdata1_d = bus.mem_rdata;
            else         rdata0_d = bus.mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (grant) begin
      we_d       = grant_id ? bus.rq1_we    : bus.rq0_we;
      addr_d     = grant_id ? bus.rq1_addr  : bus.rq0_addr;
      wdata_d    = grant_id ? bus.rq1_wdata : bus.rq0_wdata;
      owner_d    = grant_id;
      last_gnt_d = grant_id;
      cnt_d      = LAT_M1;
      state_d    = ACCESS;
    end
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Output decode, purely from registers
  always_comb begin
    bus.mem_en    = (state_q == ACCESS);
    bus.mem_we    = first_acc && we_q;
    bus.mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
    bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    bus.rq0_gnt   = first_acc && !owner_q;
    bus.rq1_gnt   = first_acc &&  owner_q;
    bus.rq0_done  = (state_q == DONE) && !owner_q;
    bus.rq1_done  = (state_q == DONE) &&  owner_q;
    bus.rq0_rdata = rdata0_q;
    bus.rq1_rdata = rdata1_q;
    bus.busy      = (state_q != IDLE);
    bus.state     = state_q;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and sequencer for the single shared memory port used by the multicycle processor. Two requesters share one memory port: requester 0 is the processor controller, for fetch, load and store; requester 1 is the program loader/debug port. The block latches one request at a time, drives the memory for a fixed latency, returns read data and signals completion. It sits between the controller/datapath memory-address mux and the memory array.

## Interface
Parameters:
- DATA_W, 32, data width.
- ADDR_W, 8, address width.
- MEM_LAT, 2, memory access cycles per transaction; legal values 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rqN_req  in  1  request from requester N (N = 0, 1)
- rqN_we  in  1  1 = write, 0 = read
- rqN_addr  in  ADDR_W  address
- rqN_wdata  in  DATA_W  write data
- rqN_gnt  out  1  one-cycle pulse: request N accepted
- rqN_done  out  1  one-cycle pulse: transaction N complete
- rqN_rdata  out  DATA_W  last read data for requester N
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- state  out  2  IDLE=00, ACCESS=01, DONE=10

## Operation
- **Registered state:** state, owner, last_gnt, cnt, and the latched we/addr/wdata are all registers. All outputs are decoded from registers; no output is combinational from the inputs.
- **Reset:**
  - state=IDLE, last_gnt=1 (so requester 0 wins the first tie), cnt=0.
  - Latched we/addr/wdata and both rdata registers = 0.
  - Every output = 0.
- **IDLE:**
  - No request: stay in IDLE.
  - Exactly one rqN_req=1: grant N.
  - Both requesting: grant the requester that is not last_gnt.
  - On grant:
    - latch we, addr and wdata;
    - owner=N, last_gnt=N, cnt=MEM_LAT-1;
    - go to ACCESS.
- **ACCESS:**
  - mem_en=1. mem_addr and mem_wdata come from the latched values.
  - mem_we = latched we, but only in the first ACCESS cycle, so a write commits exactly once.
  - cnt>0: decrement cnt.
  - cnt==0:
    - for a read, capture mem_rdata into rq[owner]_rdata;
    - go to DONE.
- **DONE:**
  - rq[owner]_done=1 for one cycle.
  - The owner's req is ignored in this cycle; the owner must drop req on seeing done.
  - If the other requester is requesting, grant it directly (DONE -> ACCESS, same latch actions as IDLE). Otherwise go to IDLE.
- **rqN_gnt** is high during the first ACCESS cycle of requester N's transaction.
- **rdata hold:** rqN_rdata holds its value until the next read by requester N completes. Writes leave it unchanged.
- **Input changes after grant:** changes to req, we, addr or wdata after grant are ignored. A req dropped after grant does not abort the transaction.
- **Request withdrawn before grant:** no transaction and no pulses.
- **Reset mid-transaction:** the transaction aborts. From the next cycle state=IDLE, all outputs are 0, no done is issued, and rdata is cleared.

## Timing
- Request sampled high in IDLE at cycle T:
  - gnt in T+1;
  - mem_en in T+1 .. T+MEM_LAT;
  - mem_we (for a write) in T+1 only;
  - mem_rdata sampled at the edge ending T+MEM_LAT;
  - done and valid rdata in T+MEM_LAT+1.
- Request-to-done latency = MEM_LAT+1 cycles.
- Back-to-back alternating owners: one transaction every MEM_LAT+1 cycles, with no IDLE cycle in between.
- Same owner re-requesting: at least one IDLE cycle between transactions, so the period is MEM_LAT+2 cycles.
- MEM_LAT=1: ACCESS lasts one cycle; gnt and mem_we coincide in that cycle.

## Test plan
1. **Single read:** MEM_LAT=2. rq0 read addr 0x10 at T; memory returns 0xDEADBEEF. Required: gnt0@T+1; mem_en@T+1..T+2 with mem_addr=0x10; done0@T+3; rq0_rdata=0xDEADBEEF.
2. **Single write:** rq1 write addr 0x20, data 0x12345678. Required: mem_we high for exactly 1 cycle with mem_addr=0x20 and mem_wdata=0x12345678; done1 pulse; rq1_rdata unchanged.
3. **Simultaneous requests after reset:** both requesters request. Required: rq0 is granted first; rq1 gnt arrives in the cycle after done0, with no IDLE cycle; done1 arrives 3 cycles after done0.
4. **Fairness:** both requesters hold req continuously for 6 transactions. Required: grant order 0,1,0,1,0,1; busy stays 1 throughout.
5. **Reset mid-transaction:** assert reset in the 2nd ACCESS cycle. Required: next cycle state=00, mem_en=0, and no done ever issued. A following rq0 read completes normally with latency MEM_LAT+1.
6. **Input stability:** change rq0_addr from 0x10 to 0x55 during ACCESS. Required: mem_addr stays 0x10 for the whole transaction.
